// File: rtl/bus_slave_mem_pkg.sv
// Shared types and bus polarity constants for the bus_slave_mem memory slave.
package bus_slave_mem_pkg;

  localparam logic BUS_ENABLE  = 1'b0;
  localparam logic BUS_DISABLE = 1'b1;
  localparam logic BUS_READ    = 1'b1;
  localparam logic BUS_WRITE   = 1'b0;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Transfer attributes captured when a request is sampled in IDLE.
  typedef struct packed {
    logic              rw;
    logic [DATA_W-1:0] wr_data;
  } xfer_t;

endpackage

// File: rtl/bus_slave_ram.sv
// Single-port-write / synchronous-read word RAM. Only the read register is reset.
module bus_slave_ram
  import bus_slave_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register returns to zero whenever no read is presented, keeping the bus OR-able.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/bus_slave_mem.sv
// Bus memory slave: IDLE/WAIT/READY handshake FSM with programmable wait states.
module bus_slave_mem
  import bus_slave_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_cs_,
  input  logic              s_as_,
  input  logic              s_rw,
  input  logic [31:0]       s_addr,
  input  logic [31:0]       s_wr_data,
  output logic [31:0]       s_rd_data,
  output logic              s_rdy_
);

  localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_t            state_q, state_d;
  wait_cnt_t         cnt_q;
  logic [ADDR_W-1:0] addr_q;
  xfer_t             xfer_q;

  logic              req_c;
  logic [ADDR_W-1:0] word_addr_c;
  logic              unused_addr_c;
  logic              cur_rw_c;
  logic [ADDR_W-1:0] cur_addr_c;
  logic              ram_we_c;
  logic              ram_rd_en_c;

  assign req_c         = (s_cs_ == BUS_ENABLE) && (s_as_ == BUS_ENABLE);
  assign word_addr_c   = s_addr[ADDR_W+1:2];
  assign unused_addr_c = ^{s_addr[31:ADDR_W+2], s_addr[1:0]};

  // With zero wait states the read is launched on the sampling edge, before capture.
  assign cur_rw_c   = (state_q == ST_IDLE) ? s_rw        : xfer_q.rw;
  assign cur_addr_c = (state_q == ST_IDLE) ? word_addr_c : addr_q;

  assign ram_rd_en_c = reset && (state_d == ST_READY) && (cur_rw_c == BUS_READ);
  assign ram_we_c    = reset && (state_q == ST_READY) && (xfer_q.rw == BUS_WRITE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          state_d = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      xfer_q  <= '0;
      s_rdy_  <= BUS_DISABLE;
    end else begin
      state_q <= state_d;
      s_rdy_  <= (state_d == ST_READY) ? BUS_ENABLE : BUS_DISABLE;
      if ((state_q == ST_IDLE) && req_c) begin
        addr_q         <= word_addr_c;
        xfer_q.rw      <= s_rw;
        xfer_q.wr_data <= s_wr_data;
        cnt_q          <= WAIT_CNT_W'(WAIT_LOAD);
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - WAIT_CNT_W'(1);
      end
    end
  end

  bus_slave_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (ram_we_c),
    .wr_addr (addr_q),
    .wr_data (xfer_q.wr_data),
    .rd_en   (ram_rd_en_c),
    .rd_addr (cur_addr_c),
    .rd_data (s_rd_data)
  );

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem with three instances: WAIT_CYCLES = 1, 0 and 3.
module tb_bus_slave_mem;
  import bus_slave_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        cs_   [3];
  logic        as_   [3];
  logic        rw    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic [31:0] rd    [3];
  logic        rdy_  [3];

  int n_checks = 0;
  int n_pass   = 0;

  bus_slave_mem #(.WAIT_CYCLES(1), .ADDR_W(10)) u_dut_w1 (
    .clk(clk), .reset(reset), .s_cs_(cs_[0]), .s_as_(as_[0]), .s_rw(rw[0]),
    .s_addr(addr[0]), .s_wr_data(wdat[0]), .s_rd_data(rd[0]), .s_rdy_(rdy_[0]));

  bus_slave_mem #(.WAIT_CYCLES(0), .ADDR_W(10)) u_dut_w0 (
    .clk(clk), .reset(reset), .s_cs_(cs_[1]), .s_as_(as_[1]), .s_rw(rw[1]),
    .s_addr(addr[1]), .s_wr_data(wdat[1]), .s_rd_data(rd[1]), .s_rdy_(rdy_[1]));

  bus_slave_mem #(.WAIT_CYCLES(3), .ADDR_W(10)) u_dut_w3 (
    .clk(clk), .reset(reset), .s_cs_(cs_[2]), .s_as_(as_[2]), .s_rw(rw[2]),
    .s_addr(addr[2]), .s_wr_data(wdat[2]), .s_rd_data(rd[2]), .s_rdy_(rdy_[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One complete transfer on instance k; s_rdy_ must fall WAIT_CYCLES+1 cycles after sampling.
  task automatic xfer(input int k, input logic dir, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input string tag);
    int lat;
    int exp_lat;
    exp_lat = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    @(negedge clk);
    cs_[k] = 1'b0; as_[k] = 1'b0; rw[k] = dir; addr[k] = a; wdat[k] = wd;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (rdy_[k] == 1'b0) lat = n;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    if (dir == BUS_READ) check({tag, " rd_data"}, 64'(rd[k]), 64'(exp_rd));
    else                 check({tag, " rd_data zero on write"}, 64'(rd[k]), 64'h0);
    cs_[k] = 1'b1; as_[k] = 1'b1;
    @(negedge clk);
    check({tag, " back to idle"}, {31'h0, rdy_[k], rd[k]}, {31'h0, 1'b1, 32'h0});
  endtask

  initial begin
    int lows;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cs_[k] = 1'b1; as_[k] = 1'b1; rw[k] = 1'b1; addr[k] = '0; wdat[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset state dut%0d", k), {31'h0, rdy_[k], rd[k]}, {31'h0, 1'b1, 32'h0});
    end
    reset = 1'b1;

    // One wait state: write then read back.
    xfer(0, BUS_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, "w1 write 0x10");
    xfer(0, BUS_READ,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "w1 read 0x10");

    // Aliasing above ADDR_W+1 and ignored byte-lane bits.
    xfer(0, BUS_WRITE, 32'h0000_1004, 32'hA5A5_A5A5, 32'h0, "w1 write 0x1004");
    xfer(0, BUS_READ,  32'h0000_0007, 32'h0,         32'hA5A5_A5A5, "w1 read 0x7 alias");
    xfer(0, BUS_READ,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "w1 reread 0x10");

    // Zero wait states: preload then back-to-back reads with request held.
    xfer(1, BUS_WRITE, 32'h0000_0000, 32'h0101_0101, 32'h0, "w0 write 0x0");
    xfer(1, BUS_WRITE, 32'h0000_0004, 32'h0202_0202, 32'h0, "w0 write 0x4");
    @(negedge clk);
    cs_[1] = 1'b0; as_[1] = 1'b0; rw[1] = BUS_READ; addr[1] = 32'h0;
    @(negedge clk);
    check("b2b first rdy", 64'(rdy_[1]), 64'h0);
    check("b2b first data", 64'(rd[1]), 64'h0101_0101);
    addr[1] = 32'h4;
    @(negedge clk);
    check("b2b idle gap", {31'h0, rdy_[1], rd[1]}, {31'h0, 1'b1, 32'h0});
    @(negedge clk);
    check("b2b second rdy", 64'(rdy_[1]), 64'h0);
    check("b2b second data", 64'(rd[1]), 64'h0202_0202);
    cs_[1] = 1'b1; as_[1] = 1'b1;
    @(negedge clk);
    check("b2b end idle", {31'h0, rdy_[1], rd[1]}, {31'h0, 1'b1, 32'h0});

    // Three wait states: abort a write just before it would complete.
    xfer(2, BUS_WRITE, 32'h0000_0020, 32'h1111_2222, 32'h0, "w3 write 0x20");
    @(negedge clk);
    cs_[2] = 1'b0; as_[2] = 1'b0; rw[2] = BUS_WRITE; addr[2] = 32'h20; wdat[2] = 32'h1234_5678;
    lows = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy_[2] == 1'b0) lows++;
    end
    as_[2] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rdy_[2] == 1'b0) lows++;
    end
    cs_[2] = 1'b1;
    check("abort no rdy", 64'(lows), 64'h0);
    xfer(2, BUS_READ, 32'h0000_0020, 32'h0, 32'h1111_2222, "w3 read after abort");

    // Reset during WAIT of a write.
    xfer(0, BUS_WRITE, 32'h0000_0030, 32'hCAFE_F00D, 32'h0, "w1 write 0x30");
    @(negedge clk);
    cs_[0] = 1'b0; as_[0] = 1'b0; rw[0] = BUS_WRITE; addr[0] = 32'h30; wdat[0] = 32'h0BAD_F00D;
    @(negedge clk);
    check("in wait rdy high", 64'(rdy_[0]), 64'h1);
    reset = 1'b0;
    @(negedge clk);
    check("reset in wait", {31'h0, rdy_[0], rd[0]}, {31'h0, 1'b1, 32'h0});
    reset = 1'b1; cs_[0] = 1'b1; as_[0] = 1'b1;
    xfer(0, BUS_READ, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, "w1 read after reset");

    // Strobe without chip select must never respond.
    @(negedge clk);
    cs_[0] = 1'b1; as_[0] = 1'b0; rw[0] = BUS_READ; addr[0] = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("no cs cycle %0d", i), {31'h0, rdy_[0], rd[0]}, {31'h0, 1'b1, 32'h0});
    end
    as_[0] = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
